// File: rtl/lcd_result_display_if.sv
// Result-record handshake from the CPU plus the character-LCD pins.
// The CPU side uses the master modport, the display stage the slave modport.
interface lcd_result_display_if;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_opcode;
  logic [3:0]  req_reg_addr;
  logic [15:0] req_value;
  logic [7:0]  lcd_data;
  logic        lcd_rs;
  logic        lcd_rw;
  logic        lcd_en;
  logic        lcd_on;

  modport master (
    output req_valid, req_opcode, req_reg_addr, req_value,
    input  req_ready, lcd_data, lcd_rs, lcd_rw, lcd_en, lcd_on
  );

  modport slave (
    input  req_valid, req_opcode, req_reg_addr, req_value,
    output req_ready, lcd_data, lcd_rs, lcd_rw, lcd_en, lcd_on
  );
endinterface

// File: rtl/lcd_result_display.sv
// Display stage of the mini CPU: formats one result record per instruction
// and writes it to a 16x2 HD44780 LCD (8-bit, write-only), including power-up init.
// Optional macro LCD_HEX_VIEW_EN appends " hXXXX" (raw value in hex) to line 2.
module lcd_result_display #(
  parameter int unsigned POWERUP_CYCLES = 750000,
  parameter int unsigned EN_HIGH_CYCLES = 12,
  parameter int unsigned CMD_CYCLES     = 2000,
  parameter int unsigned CLEAR_CYCLES   = 82000
) (
  input logic clock,
  input logic reset,
  lcd_result_display_if.slave bus
);
  localparam int unsigned MAX_A   = (POWERUP_CYCLES > CLEAR_CYCLES) ? POWERUP_CYCLES : CLEAR_CYCLES;
  localparam int unsigned MAX_B   = (CMD_CYCLES > EN_HIGH_CYCLES) ? CMD_CYCLES : EN_HIGH_CYCLES;
  localparam int unsigned MAX_C   = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int unsigned MAX_CYC = (MAX_C > 32) ? MAX_C : 32;
  localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);
  localparam int unsigned DD_LAST = 16;

  localparam logic [2:0] PWR_WAIT = 3'd0;
  localparam logic [2:0] INIT     = 3'd1;
  localparam logic [2:0] IDLE     = 3'd2;
  localparam logic [2:0] CONVERT  = 3'd3;
  localparam logic [2:0] WR_L1    = 3'd4;
  localparam logic [2:0] WR_L2    = 3'd5;
  localparam logic [2:0] CLR      = 3'd6;

  localparam logic [1:0] PH_SETUP = 2'd0;
  localparam logic [1:0] PH_HIGH  = 2'd1;
  localparam logic [1:0] PH_WAIT  = 2'd2;

  logic [2:0]       state, state_n, after_state;
  logic [1:0]       phase, phase_n;
  logic [4:0]       idx, idx_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             take, byte_last, wait_done, byte_state_n;

  logic [2:0]  op_q;
  logic [3:0]  reg_q;
  logic        neg_q;
  logic [16:0] bin_q;
  logic [19:0] bcd_q, bcd_adj;
  logic [16:0] mag_c;
`ifdef LCD_HEX_VIEW_EN
  logic [15:0] val_q;
`endif

  logic       ready_q, rs_q, en_q, on_q;
  logic [7:0] data_q;
  logic [7:0] char_byte;
  logic       char_rs;
  logic [3:0] pos;
  logic [31:0] mnem;
  logic [3:0] reg_ones;

  assign bus.req_ready = ready_q;
  assign bus.lcd_data  = data_q;
  assign bus.lcd_rs    = rs_q;
  assign bus.lcd_rw    = 1'b0;
  assign bus.lcd_en    = en_q;
  assign bus.lcd_on    = on_q;

  assign mag_c = bus.req_value[15] ? (17'h10000 - {1'b0, bus.req_value}) : {1'b0, bus.req_value};
  assign byte_state_n = (state_n == INIT) || (state_n == WR_L1) || (state_n == WR_L2) || (state_n == CLR);

  // Next-state logic: state sequencing plus the per-byte setup/strobe/wait engine
  always_comb begin
    state_n     = state;
    phase_n     = phase;
    idx_n       = idx;
    cnt_n       = cnt;
    take        = 1'b0;
    byte_last   = 1'b0;
    after_state = IDLE;
    wait_done   = (!rs_q && (data_q == 8'h01)) ? (cnt == CNT_W'(CLEAR_CYCLES - 1))
                                               : (cnt == CNT_W'(CMD_CYCLES - 1));
    case (state)
      INIT:    byte_last = (idx == 5'd3);
      WR_L1:   begin byte_last = (idx == 5'd16); after_state = WR_L2; end
      WR_L2:   byte_last = (idx == 5'd16);
      CLR:     byte_last = 1'b1;
      default: ;
    endcase
    case (state)
      PWR_WAIT: begin
        if (cnt == CNT_W'(POWERUP_CYCLES - 1)) begin
          state_n = INIT; phase_n = PH_SETUP; idx_n = '0; cnt_n = '0;
        end else cnt_n = cnt + CNT_W'(1);
      end
      IDLE: begin
        if (bus.req_valid && ready_q) begin
          take    = 1'b1;
          state_n = (bus.req_opcode == 3'b110) ? CLR : CONVERT;
          phase_n = PH_SETUP; idx_n = '0; cnt_n = '0;
        end
      end
      CONVERT: begin
        if (cnt == CNT_W'(DD_LAST)) begin
          state_n = WR_L1; phase_n = PH_SETUP; idx_n = '0; cnt_n = '0;
        end else cnt_n = cnt + CNT_W'(1);
      end
      INIT, WR_L1, WR_L2, CLR: begin
        case (phase)
          PH_SETUP: begin phase_n = PH_HIGH; cnt_n = '0; end
          PH_HIGH: begin
            if (cnt == CNT_W'(EN_HIGH_CYCLES - 1)) begin phase_n = PH_WAIT; cnt_n = '0; end
            else cnt_n = cnt + CNT_W'(1);
          end
          default: begin
            if (wait_done) begin
              phase_n = PH_SETUP; cnt_n = '0;
              if (byte_last) begin idx_n = '0; state_n = after_state; end
              else idx_n = idx + 5'd1;
            end else cnt_n = cnt + CNT_W'(1);
          end
        endcase
      end
      default: begin state_n = PWR_WAIT; phase_n = PH_SETUP; idx_n = '0; cnt_n = '0; end
    endcase
  end

  // State and sequencing counters
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= PWR_WAIT; phase <= PH_SETUP; idx <= '0; cnt <= '0;
    end else begin
      state <= state_n; phase <= phase_n; idx <= idx_n; cnt <= cnt_n;
    end
  end

  // Double-dabble correction: add 3 to every BCD digit of 5 or more before shifting
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < 5; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
  end

  // Record capture and sequential binary-to-BCD conversion, one bit per cycle
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      op_q <= '0; reg_q <= '0; neg_q <= 1'b0; bin_q <= '0; bcd_q <= '0;
`ifdef LCD_HEX_VIEW_EN
      val_q <= '0;
`endif
    end else if (take) begin
      op_q  <= bus.req_opcode;
      reg_q <= bus.req_reg_addr;
      neg_q <= bus.req_value[15];
      bin_q <= mag_c;
      bcd_q <= '0;
`ifdef LCD_HEX_VIEW_EN
      val_q <= bus.req_value;
`endif
    end else if (state == CONVERT) begin
      bcd_q <= {bcd_adj[18:0], bin_q[16]};
      bin_q <= {bin_q[15:0], 1'b0};
    end
  end

`ifdef LCD_HEX_VIEW_EN
  function automatic logic [7:0] hex_char(input logic [3:0] n);
    return (n < 4'd10) ? {4'h3, n} : 8'(8'h37 + {4'h0, n});
  endfunction
`endif

  // Byte selection for the byte about to be presented (command or character)
  always_comb begin
    pos       = 4'(idx_n - 5'd1);
    char_rs   = 1'b1;
    char_byte = 8'h20;
    reg_ones  = (reg_q > 4'd9) ? (reg_q - 4'd10) : reg_q;
    case (op_q)
      3'b000:  mnem = "LOAD";
      3'b001:  mnem = "ADD ";
      3'b010:  mnem = "ADDI";
      3'b011:  mnem = "SUB ";
      3'b100:  mnem = "SUBI";
      3'b101:  mnem = "MUL ";
      3'b111:  mnem = "DPLY";
      default: mnem = "    ";
    endcase
    case (state_n)
      INIT: begin
        char_rs = 1'b0;
        case (idx_n)
          5'd0:    char_byte = 8'h38;
          5'd1:    char_byte = 8'h0C;
          5'd2:    char_byte = 8'h01;
          default: char_byte = 8'h06;
        endcase
      end
      CLR: begin char_rs = 1'b0; char_byte = 8'h01; end
      WR_L1: begin
        if (idx_n == 5'd0) begin char_rs = 1'b0; char_byte = 8'h80; end
        else case (pos)
          4'd0:    char_byte = mnem[31:24];
          4'd1:    char_byte = mnem[23:16];
          4'd2:    char_byte = mnem[15:8];
          4'd3:    char_byte = mnem[7:0];
          4'd5:    char_byte = 8'h52;
          4'd6:    char_byte = (reg_q > 4'd9) ? 8'h31 : 8'h30;
          4'd7:    char_byte = {4'h3, reg_ones};
          default: char_byte = 8'h20;
        endcase
      end
      WR_L2: begin
        if (idx_n == 5'd0) begin char_rs = 1'b0; char_byte = 8'hC0; end
        else case (pos)
          4'd0:    char_byte = neg_q ? 8'h2D : 8'h2B;
          4'd1:    char_byte = {4'h3, bcd_q[19:16]};
          4'd2:    char_byte = {4'h3, bcd_q[15:12]};
          4'd3:    char_byte = {4'h3, bcd_q[11:8]};
          4'd4:    char_byte = {4'h3, bcd_q[7:4]};
          4'd5:    char_byte = {4'h3, bcd_q[3:0]};
`ifdef LCD_HEX_VIEW_EN
          4'd7:    char_byte = 8'h68;
          4'd8:    char_byte = hex_char(val_q[15:12]);
          4'd9:    char_byte = hex_char(val_q[11:8]);
          4'd10:   char_byte = hex_char(val_q[7:4]);
          4'd11:   char_byte = hex_char(val_q[3:0]);
`endif
          default: char_byte = 8'h20;
        endcase
      end
      default: begin char_rs = 1'b0; char_byte = 8'h00; end
    endcase
  end

  // Registered LCD pins and handshake; data/rs load only at the setup cycle of each byte
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ready_q <= 1'b0; data_q <= 8'h00; rs_q <= 1'b0; en_q <= 1'b0; on_q <= 1'b0;
    end else begin
      on_q    <= 1'b1;
      ready_q <= (state_n == IDLE);
      en_q    <= byte_state_n && (phase_n == PH_HIGH);
      if (byte_state_n && (phase_n == PH_SETUP)) begin
        data_q <= char_byte;
        rs_q   <= char_rs;
      end
    end
  end
endmodule

// File: tb/tb_lcd_result_display.sv
// Scoreboard bench for lcd_result_display: handshakes push expected LCD bytes,
// a monitor pops and checks each strobed byte, strobe width and wait gaps.
module tb_lcd_result_display;
  localparam int PWR = 20;
  localparam int ENH = 4;
  localparam int CMD = 8;
  localparam int CLW = 30;
  localparam int NV  = 9;

  typedef struct packed {
    logic       rs;
    logic [7:0] data;
    logic [7:0] wt;
    logic       last;
  } exp_t;

  logic clock;
  logic reset;
  lcd_result_display_if bus();

  lcd_result_display #(
    .POWERUP_CYCLES(PWR), .EN_HIGH_CYCLES(ENH), .CMD_CYCLES(CMD), .CLEAR_CYCLES(CLW)
  ) dut (
    .clock(clock), .reset(reset), .bus(bus)
  );

  initial clock = 1'b0;
  always #10 clock = ~clock;

  int errors = 0;
  int checks = 0;
  int hs_count = 0;
  int cur_idx = 0;
  exp_t exp_q[$];

  logic [2:0]  op_tab [NV];
  logic [3:0]  reg_tab[NV];
  logic [15:0] val_tab[NV];
  string l1_tab[NV];
  string l2_tab[NV];
  string hx_tab[NV];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_byte(input logic rs, input logic [7:0] d, input int wt, input bit last);
    exp_t e;
    e.rs = rs; e.data = d; e.wt = 8'(wt); e.last = last;
    exp_q.push_back(e);
  endtask

  task automatic push_init();
    push_byte(1'b0, 8'h38, CMD, 1'b0);
    push_byte(1'b0, 8'h0C, CMD, 1'b0);
    push_byte(1'b0, 8'h01, CLW, 1'b0);
    push_byte(1'b0, 8'h06, CMD, 1'b1);
  endtask

  task automatic push_record(input int i);
    string l1, l2;
    if (op_tab[i] == 3'b110) begin
      push_byte(1'b0, 8'h01, CLW, 1'b1);
      return;
    end
    l1 = {l1_tab[i], "        "};
`ifdef LCD_HEX_VIEW_EN
    l2 = {l2_tab[i], " h", hx_tab[i], "    "};
`else
    l2 = {l2_tab[i], "          "};
`endif
    push_byte(1'b0, 8'h80, CMD, 1'b0);
    for (int k = 0; k < 16; k++) push_byte(1'b1, l1[k], CMD, 1'b0);
    push_byte(1'b0, 8'hC0, CMD, 1'b0);
    for (int k = 0; k < 16; k++) push_byte(1'b1, l2[k], CMD, k == 15);
  endtask

  // Handshake sampler: the record seen here is the one the next edge captures
  always @(negedge clock) begin
    if (!reset && bus.req_valid && bus.req_ready) begin
      push_record(cur_idx);
      hs_count++;
    end
  end

  // Output monitor
  logic en_prev = 1'b0, ready_prev = 1'b0;
  bit   have_cur = 0, have_prev = 0;
  int   high_cnt = 0, low_cnt = 0;
  exp_t cur, prev;
  always @(negedge clock) begin
    if (reset) begin
      en_prev = 1'b0; ready_prev = 1'b0; have_cur = 0; have_prev = 0;
      high_cnt = 0; low_cnt = 0;
    end else begin
      if (bus.req_ready && !ready_prev) begin
        chk("ready_after_last_byte", int'(have_prev && prev.last), 1);
        if (have_prev && prev.last) chk("final_wait", low_cnt, int'(prev.wt));
        have_prev = 0;
      end
      if (bus.lcd_en && !en_prev) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL extra_byte: actual rs=%0d data=0x%0h expected no byte at %0t",
                   bus.lcd_rs, bus.lcd_data, $time);
        end else begin
          cur = exp_q.pop_front();
          have_cur = 1;
          chk("byte_rs", int'(bus.lcd_rs), int'(cur.rs));
          chk("byte_data", int'(bus.lcd_data), int'(cur.data));
          chk("ready_low_in_xfer", int'(bus.req_ready), 0);
          if (have_prev && !prev.last) chk("byte_gap", low_cnt, int'(prev.wt) + 1);
        end
        high_cnt = 1;
      end else if (bus.lcd_en) begin
        high_cnt++;
      end else if (en_prev) begin
        chk("en_width", high_cnt, ENH);
        if (have_cur) begin
          chk("data_hold", int'({bus.lcd_rs, bus.lcd_data}), int'({cur.rs, cur.data}));
          prev = cur; have_prev = 1; have_cur = 0;
        end
        low_cnt = 1;
      end else begin
        low_cnt++;
      end
      en_prev = bus.lcd_en;
      ready_prev = bus.req_ready;
    end
  end

  task automatic check_reset_outs(input string tag);
    chk({tag, "_ready"}, int'(bus.req_ready), 0);
    chk({tag, "_data"},  int'(bus.lcd_data), 0);
    chk({tag, "_rs"},    int'(bus.lcd_rs), 0);
    chk({tag, "_rw"},    int'(bus.lcd_rw), 0);
    chk({tag, "_en"},    int'(bus.lcd_en), 0);
    chk({tag, "_on"},    int'(bus.lcd_on), 0);
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (!bus.req_ready && n < 5000) begin @(posedge clock); #2; n++; end
    if (!bus.req_ready) chk({tag, "_ready_timeout"}, 0, 1);
  endtask

  task automatic send(input int i);
    wait_ready("send");
    bus.req_valid = 1'b1;
    bus.req_opcode = op_tab[i]; bus.req_reg_addr = reg_tab[i]; bus.req_value = val_tab[i];
    cur_idx = i;
    @(posedge clock); #2;
    bus.req_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (!(exp_q.size() == 0 && bus.req_ready) && n < 20000) begin @(posedge clock); #2; n++; end
    chk({tag, "_drained"}, exp_q.size(), 0);
    chk({tag, "_idle_ready"}, int'(bus.req_ready), 1);
  endtask

  initial begin
    op_tab[0]=3'b010; reg_tab[0]=4'd3;  val_tab[0]=16'hFFFB; l1_tab[0]="ADDI R03"; l2_tab[0]="-00005"; hx_tab[0]="FFFB";
    op_tab[1]=3'b111; reg_tab[1]=4'd15; val_tab[1]=16'h8000; l1_tab[1]="DPLY R15"; l2_tab[1]="-32768"; hx_tab[1]="8000";
    op_tab[2]=3'b111; reg_tab[2]=4'd15; val_tab[2]=16'h7FFF; l1_tab[2]="DPLY R15"; l2_tab[2]="+32767"; hx_tab[2]="7FFF";
    op_tab[3]=3'b000; reg_tab[3]=4'd0;  val_tab[3]=16'h0000; l1_tab[3]="LOAD R00"; l2_tab[3]="+00000"; hx_tab[3]="0000";
    op_tab[4]=3'b001; reg_tab[4]=4'd10; val_tab[4]=16'h04D2; l1_tab[4]="ADD  R10"; l2_tab[4]="+01234"; hx_tab[4]="04D2";
    op_tab[5]=3'b011; reg_tab[5]=4'd7;  val_tab[5]=16'hFF38; l1_tab[5]="SUB  R07"; l2_tab[5]="-00200"; hx_tab[5]="FF38";
    op_tab[6]=3'b100; reg_tab[6]=4'd9;  val_tab[6]=16'h0001; l1_tab[6]="SUBI R09"; l2_tab[6]="+00001"; hx_tab[6]="0001";
    op_tab[7]=3'b101; reg_tab[7]=4'd12; val_tab[7]=16'h3039; l1_tab[7]="MUL  R12"; l2_tab[7]="+12345"; hx_tab[7]="3039";
    op_tab[8]=3'b110; reg_tab[8]=4'd5;  val_tab[8]=16'h1234; l1_tab[8]="";         l2_tab[8]="";       hx_tab[8]="";

    reset = 1'b1;
    bus.req_valid = 1'b0; bus.req_opcode = '0; bus.req_reg_addr = '0; bus.req_value = '0;
    #1;
    check_reset_outs("por");
    push_init();
    repeat (3) @(posedge clock);
    @(negedge clock) reset = 1'b0;
    @(posedge clock); #1;
    chk("lcd_on_after_release", int'(bus.lcd_on), 1);
    chk("ready_low_pwr_wait", int'(bus.req_ready), 0);
    wait_ready("init");

    // Directed records, including sign and magnitude extremes and clear
    send(0); send(1); send(2); send(8); send(3);
    send(4); send(5); send(6); send(7);
    drain("directed");

    // Valid held high with data changing every cycle
    begin
      int k = 0, n = 0, target;
      target = hs_count + 4;
      bus.req_valid = 1'b1;
      while (hs_count < target && n < 8000) begin
        bus.req_opcode = op_tab[k]; bus.req_reg_addr = reg_tab[k]; bus.req_value = val_tab[k];
        cur_idx = k;
        k = (k + 1) % 8;
        @(posedge clock); #2;
        n++;
      end
      bus.req_valid = 1'b0;
      chk("stream_handshakes", hs_count, target);
    end
    drain("stream");

    // Reset while the strobe is high inside line 1
    send(4);
    begin
      int n = 0;
      while (!(bus.lcd_en && bus.lcd_rs) && n < 2000) begin @(negedge clock); n++; end
      chk("reached_line1_char", int'(bus.lcd_en && bus.lcd_rs), 1);
    end
    #3 reset = 1'b1;
    #1 check_reset_outs("mid_reset");
    exp_q.delete();
    push_init();
    repeat (2) @(posedge clock);
    @(negedge clock) reset = 1'b0;
    wait_ready("reinit");
    chk("reinit_drained", exp_q.size(), 0);
    send(1);
    drain("post_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/lcd_result_display.md
Name: lcd_result_display

Overview:
- Downstream display stage of the mini CPU.
- Accepts one result record per executed instruction: opcode, destination register and 16-bit value.
- Formats the record as ASCII and drives the board's 16x2 HD44780-compatible character LCD in 8-bit write-only mode.
- Owns LCD power-up initialisation and all command/data timing. The CPU control FSM waits on req_ready before it returns to idle.

Parameters:
- POWERUP_CYCLES, 750000: clock cycles to wait after reset before the first LCD command (15 ms at 50 MHz).
- EN_HIGH_CYCLES, 12: cycles lcd_en is held high per byte.
- CMD_CYCLES, 2000: wait after any byte except clear (40 us).
- CLEAR_CYCLES, 82000: wait after command 0x01 (1.64 ms).

Ports:
- clock  in  1  system clock, 50 MHz.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  a result record is presented.
- req_ready  out  1  block can accept a record.
- req_opcode  in  3  instruction opcode.
- req_reg_addr  in  4  destination register index.
- req_value  in  16  result, two's complement.
- lcd_data  out  8  LCD data bus.
- lcd_rs  out  1  0 = command, 1 = character.
- lcd_rw  out  1  tied 0 (write only).
- lcd_en  out  1  LCD enable strobe.
- lcd_on  out  1  LCD power/backlight; 1 after reset release.

Behaviour:
- Reset (asynchronous, any state): req_ready=0, lcd_data=0x00, lcd_rs=0, lcd_rw=0, lcd_en=0, lcd_on=0. Any captured record is discarded. State goes to PWR_WAIT.
- Reset mid-transfer: the strobe drops immediately and the full initialisation runs again.
- lcd_on=1 from the first clock after reset deassertion.
- States: PWR_WAIT, INIT, IDLE, CONVERT, WR_L1, WR_L2, CLR.
- PWR_WAIT: count POWERUP_CYCLES, then go to INIT.
- INIT: send the commands 0x38, 0x0C, 0x01, 0x06 in that order, then go to IDLE.
- Byte transfer sub-sequence, identical for every byte:
  - Cycle 0: lcd_rs and lcd_data set, lcd_en=0.
  - Then lcd_en=1 for EN_HIGH_CYCLES.
  - Then lcd_en=0 while waiting CMD_CYCLES (CLEAR_CYCLES if the byte is command 0x01).
  - lcd_data and lcd_rs are held stable until the wait ends.
- IDLE: req_ready=1.
  - The record is captured on the clock edge where req_valid && req_ready.
  - req_ready is 0 from the next cycle until the block returns to IDLE.
  - req_ready is never 1 outside IDLE.
  - Input changes while not ready are ignored.
- Opcode 110 (CLR): go to CLR, send 0x01 only, return to IDLE. No text is written.
- All other opcodes go to CONVERT:
  - Compute the magnitude: |value| as a 17-bit quantity, so 0x8000 gives 32768.
  - Record the sign.
  - Convert the magnitude to 5 BCD digits with sequential double-dabble, one bit per cycle, 17 cycles. The conversion is not combinational.
  - Then go to WR_L1.
- WR_L1: command 0x80, then 16 characters.
  - Characters 0-3: mnemonic padded with spaces. 000 "LOAD", 001 "ADD ", 010 "ADDI", 011 "SUB ", 100 "SUBI", 101 "MUL ", 111 "DPLY".
  - Character 4: space.
  - Character 5: 'R'.
  - Characters 6-7: register index as two decimal digits, "00" to "15".
  - Characters 8-15: spaces.
- WR_L2: command 0xC0, then 16 characters.
  - Character 0: '+' for value >= 0, '-' otherwise.
  - Characters 1-5: decimal digits with leading zeros kept.
  - Characters 6-15: spaces.
  - Then return to IDLE.
- Every line is always written in full, 16 characters; stale text is overwritten.
- Zero prints as "+00000". 0x7FFF prints as "+32767". 0x8000 prints as "-32768".

Optional Feature:
- Macro LCD_HEX_VIEW_EN.
- When defined: WR_L2 characters 6-7 are " h" and characters 8-11 are the four uppercase hex digits of the raw req_value (e.g. 0xFFFB gives "FFFB"). Characters 12-15 are spaces.
- When undefined: characters 6-15 are spaces, and no hex formatting logic is synthesised.

Test Plan:
- Reset, then release with POWERUP_CYCLES=20, CMD_CYCLES=8, CLEAR_CYCLES=30 -> bytes 0x38, 0x0C, 0x01, 0x06 all with rs=0; the 0x01 wait is 30 cycles; req_ready rises only after the final wait.
- Send opcode 010, reg 3, value 0xFFFB -> line 1 "ADDI R03" followed by 8 spaces; line 2 "-00005" followed by spaces, or "-00005 hFFFB" when LCD_HEX_VIEW_EN is defined; preceded by commands 0x80 and 0xC0.
- Send value 0x8000 (opcode 111, reg 15) then 0x7FFF -> "DPLY R15" with "-32768", then "+32767"; req_ready=0 for the whole of each transfer.
- Hold req_valid=1 continuously with changing data -> exactly one record is captured per return to IDLE; the captured values match those sampled on the handshake edge.
- Opcode 110 -> a single command byte 0x01 followed by the CLEAR_CYCLES wait; no rs=1 bytes.
- Assert reset while lcd_en=1 in WR_L1 -> all outputs reach their reset values immediately; after release, the full INIT sequence repeats before req_ready=1.
